// File: rtl/twitchcore_pkg.sv
// Shared widths and read-owner encoding for the instruction/data memory arbiter.
package twitchcore_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } own_e;

endpackage

// File: rtl/arb_pick.sv
// Two-way combinational picker: port b wins conflicts unless RR is set and b won the
// previous conflict (last_b), in which case port a wins.
module arb_pick #(
    parameter bit RR = 1'b0
) (
    input  logic a_req,
    input  logic b_req,
    input  logic last_b,
    output logic a_gnt,
    output logic b_gnt,
    output logic conflict
);

    // Resolve at most one grant from the two requests
    always_comb begin
        conflict = a_req & b_req;
        if (conflict) begin
            b_gnt = (RR == 1'b0) ? 1'b1 : ~last_b;
            a_gnt = ~b_gnt;
        end else begin
            a_gnt = a_req;
            b_gnt = b_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between a fetch port (I) and a data port (D).
// Define MEM_ARB_RR_EN for round-robin conflict resolution; otherwise D always wins.
module mem_arbiter
    import twitchcore_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  m_en,
    output logic                  m_we,
    output logic [DATA_W/8-1:0]   m_be,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W-1:0]     m_rdata
);

    own_e owner_q;
    own_e owner_d;
    logic i_pick;
    logic d_pick;
    logic conflict;
    logic last_d;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
    logic last_d_q;
    logic last_d_d;

    // Only conflicts move the round-robin flag; it records whether D won the latest one
    always_comb begin
        if (conflict) begin
            last_d_d = d_pick;
        end else begin
            last_d_d = last_d_q;
        end
    end

    // Round-robin flag register, cleared to "I won last" so the first conflict goes to D
    always_ff @(posedge clk) begin
        if (reset) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end

    assign last_d = last_d_q;
`else
    localparam bit RR_EN = 1'b0;
    assign last_d = 1'b0;
`endif

    arb_pick #(
        .RR       (RR_EN)
    ) u_pick (
        .a_req    (i_req),
        .b_req    (d_req),
        .last_b   (last_d),
        .a_gnt    (i_pick),
        .b_gnt    (d_pick),
        .conflict (conflict)
    );

    // Grants, memory command and next read owner; everything is forced quiet in reset
    always_comb begin
        i_gnt   = i_pick & ~reset;
        d_gnt   = d_pick & ~reset;
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_be    = '0;
        m_addr  = '0;
        m_wdata = '0;
        owner_d = OWN_NONE;
        if (i_gnt) begin
            m_en    = 1'b1;
            m_addr  = i_addr;
            owner_d = OWN_I;
        end else if (d_gnt) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_be    = d_be;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            owner_d = d_we ? OWN_NONE : OWN_D;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // Read return steering: only the recorded owner sees data, the other port reads 0
    always_comb begin
        i_rvalid = ~reset & (owner_q == OWN_I);
        d_rvalid = ~reset & (owner_q == OWN_D);
        if (i_rvalid) begin
            i_rdata = m_rdata;
        end else begin
            i_rdata = '0;
        end
        if (d_rvalid) begin
            d_rdata = m_rdata;
        end else begin
            d_rdata = '0;
        end
    end

    // Owner register; reset discards any read still in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic checked
// against a request-level reference model. Build with +define+MEM_ARB_RR_EN for round-robin.
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_en;
    logic          m_we;
    logic [BW-1:0] m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Environment: a single-port synchronous memory attached to the m_* bus
    logic [DW-1:0] mem [0:4095];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) begin
                for (int b = 0; b < BW; b++) begin
                    if (m_be[b]) mem[m_addr][b*8 +: 8] = m_wdata[b*8 +: 8];
                end
            end else begin
                m_rdata <= mem[m_addr];
            end
        end
    end

    // Reference model: expected memory contents, pending read (0 none, 1 I, 2 D), last conflict winner
    logic [DW-1:0] ref_mem [0:4095];
    int            pend_own = 0;
    logic [DW-1:0] pend_data = '0;
    int            last_win = 1;

    logic          exp_ig, exp_dg, exp_men, exp_mwe, exp_irv, exp_drv;
    logic [BW-1:0] exp_mbe;
    logic [AW-1:0] exp_maddr;
    logic [DW-1:0] exp_mwdata, exp_ird, exp_drd;

    task automatic model_eval();
        bit d_wins;
        exp_ig = 1'b0; exp_dg = 1'b0; exp_men = 1'b0; exp_mwe = 1'b0;
        exp_mbe = '0; exp_maddr = '0; exp_mwdata = '0;
        exp_irv = 1'b0; exp_drv = 1'b0; exp_ird = '0; exp_drd = '0;
        if (!reset) begin
`ifdef MEM_ARB_RR_EN
            d_wins = (last_win != 2);
`else
            d_wins = 1'b1;
`endif
            exp_dg = d_req && (!i_req || d_wins);
            exp_ig = i_req && !exp_dg;
            if (exp_ig) begin
                exp_men = 1'b1; exp_maddr = i_addr;
            end else if (exp_dg) begin
                exp_men = 1'b1; exp_mwe = d_we; exp_mbe = d_be;
                exp_maddr = d_addr; exp_mwdata = d_wdata;
            end
            exp_irv = (pend_own == 1);
            exp_drv = (pend_own == 2);
            exp_ird = exp_irv ? pend_data : '0;
            exp_drd = exp_drv ? pend_data : '0;
        end
    endtask

    task automatic model_commit();
        if (reset) begin
            pend_own = 0;
            last_win = 1;
        end else begin
            if (i_req && d_req) last_win = exp_dg ? 2 : 1;
            if (exp_ig) begin
                pend_own = 1; pend_data = ref_mem[i_addr];
            end else if (exp_dg && !d_we) begin
                pend_own = 2; pend_data = ref_mem[d_addr];
            end else begin
                pend_own = 0;
                if (exp_dg) begin
                    for (int b = 0; b < BW; b++) begin
                        if (d_be[b]) ref_mem[d_addr][b*8 +: 8] = d_wdata[b*8 +: 8];
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic rst, input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic dwe, input logic [BW-1:0] be,
                         input logic [AW-1:0] da, input logic [DW-1:0] wd);
        reset = rst; i_req = ir; i_addr = ia;
        d_req = dr; d_we = dwe; d_be = be; d_addr = da; d_wdata = wd;
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 12'h010, 1'b1, 1'b1, 4'hF, 12'h020, 32'hFFFF_FFFF);
        checks++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000", {i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we});
        end
        checks++;
        if ({m_be, m_addr, m_wdata, i_rdata, d_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: be=%h addr=%h wdata=%h irdata=%h drdata=%h want all 0",
                     m_be, m_addr, m_wdata, i_rdata, d_rdata);
        end
        advance();
    endtask

    task automatic test_ifetch();
        drive(1'b0, 1'b1, 12'h010, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        checks++;
        if ({i_gnt, d_gnt, m_en, m_we} !== 4'b1010 || m_addr !== 12'h010) begin
            errors++;
            $display("FAIL ifetch_gnt: gnt/dgnt/en/we=%b addr=%h want 1010 addr=010",
                     {i_gnt, d_gnt, m_en, m_we}, m_addr);
        end
        advance();
        drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'hDEAD_BEEF || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL ifetch_data: rvalid=%b rdata=%h drvalid=%b want 1 deadbeef 0",
                     i_rvalid, i_rdata, d_rvalid);
        end
        advance();
    endtask

    task automatic test_write_merge();
        logic [DW-1:0] old_word;
        logic [DW-1:0] merged;
        old_word = ref_mem[12'h020];
        merged   = {old_word[31:16], 16'h5678};
        drive(1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 4'b0011, 12'h020, 32'h1234_5678);
        checks++;
        if ({d_gnt, m_en, m_we} !== 3'b111 || m_be !== 4'b0011 || m_addr !== 12'h020 ||
            m_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write_cmd: gnt/en/we=%b be=%b addr=%h wdata=%h want 111 0011 020 12345678",
                     {d_gnt, m_en, m_we}, m_be, m_addr, m_wdata);
        end
        advance();
        drive(1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 4'b0000, 12'h020, 32'h0);
        checks++;
        if (d_rvalid !== 1'b0 || d_gnt !== 1'b1 || m_we !== 1'b0) begin
            errors++;
            $display("FAIL write_no_rvalid: drvalid=%b dgnt=%b mwe=%b want 0 1 0", d_rvalid, d_gnt, m_we);
        end
        advance();
        drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 4'b0000, 12'h000, 32'h0);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== merged || i_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL write_merge: drvalid=%b rdata=%h irvalid=%b want 1 %h 0",
                     d_rvalid, d_rdata, i_rvalid, merged);
        end
        advance();
    endtask

    task automatic test_conflict();
        logic [3:0] d_seq;
`ifdef MEM_ARB_RR_EN
        d_seq = 4'b0101;
`else
        d_seq = 4'b1111;
`endif
        drive(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        advance();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 12'h003, 1'b1, 1'b0, 4'h0, 12'h004, 32'h0);
            checks++;
            if (d_gnt !== d_seq[k] || i_gnt !== ~d_seq[k] || (i_rvalid & d_rvalid) !== 1'b0) begin
                errors++;
                $display("FAIL conflict_%0d: dgnt=%b ignt=%b rv=%b%b want dgnt=%b one grant, no double rvalid",
                         k, d_gnt, i_gnt, i_rvalid, d_rvalid, d_seq[k]);
            end
            advance();
        end
        drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        advance();
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 12'h001, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        advance();
        drive(1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 4'h0, 12'h002, 32'h0);
        checks++;
        if (d_gnt !== 1'b1 || i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== ref_mem[12'h001]) begin
            errors++;
            $display("FAIL b2b_first: dgnt=%b irv=%b drv=%b irdata=%h want 1 1 0 %h",
                     d_gnt, i_rvalid, d_rvalid, i_rdata, ref_mem[12'h001]);
        end
        advance();
        drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        checks++;
        if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== ref_mem[12'h002] || i_rdata !== '0) begin
            errors++;
            $display("FAIL b2b_second: drv=%b irv=%b drdata=%h irdata=%h want 1 0 %h 0",
                     d_rvalid, i_rvalid, d_rdata, i_rdata, ref_mem[12'h002]);
        end
        advance();
    endtask

    task automatic test_reset_inflight();
        drive(1'b0, 1'b1, 12'h005, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        advance();
        drive(1'b1, 1'b1, 12'h005, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        checks++;
        if ({i_rvalid, i_gnt, m_en} !== 3'b000 || i_rdata !== '0) begin
            errors++;
            $display("FAIL inflight_reset: irv/ignt/men=%b irdata=%h want 000 0", {i_rvalid, i_gnt, m_en}, i_rdata);
        end
        advance();
        drive(1'b0, 1'b1, 12'h006, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        checks++;
        if (i_rvalid !== 1'b0 || i_gnt !== 1'b1 || m_addr !== 12'h006) begin
            errors++;
            $display("FAIL first_after_reset: irv=%b ignt=%b addr=%h want 0 1 006", i_rvalid, i_gnt, m_addr);
        end
        advance();
        drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== ref_mem[12'h006]) begin
            errors++;
            $display("FAIL post_reset_data: irv=%b irdata=%h want 1 %h", i_rvalid, i_rdata, ref_mem[12'h006]);
        end
        advance();
    endtask

    task automatic test_drop();
        drive(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        advance();
        drive(1'b0, 1'b1, 12'h007, 1'b1, 1'b0, 4'h0, 12'h0AA, 32'h0);
        advance();
        drive(1'b0, 1'b1, 12'h008, 1'b1, 1'b0, 4'h0, 12'h0AA, 32'h0);
        checks++;
        if (d_gnt !== exp_dg || i_gnt !== exp_ig) begin
            errors++;
            $display("FAIL drop_conflict: dgnt=%b ignt=%b want %b %b", d_gnt, i_gnt, exp_dg, exp_ig);
        end
        advance();
        drive(1'b0, 1'b1, 12'h009, 1'b0, 1'b0, 4'h0, 12'h0AA, 32'h0);
        checks++;
        if (d_gnt !== 1'b0 || m_en !== 1'b1 || m_addr !== 12'h009) begin
            errors++;
            $display("FAIL drop_no_access: dgnt=%b men=%b addr=%h want 0 1 009", d_gnt, m_en, m_addr);
        end
        advance();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1), AW'($urandom_range(0, 31)),
                  $urandom_range(0, 1), $urandom_range(0, 1), BW'($urandom), AW'($urandom_range(0, 31)),
                  $urandom);
            checks++;
            if ({i_gnt, d_gnt} !== {exp_ig, exp_dg}) begin
                errors++;
                $display("FAIL rand_gnt[%0d]: got %b want %b", n, {i_gnt, d_gnt}, {exp_ig, exp_dg});
            end
            checks++;
            if ({m_en, m_we, m_be, m_addr, m_wdata} !== {exp_men, exp_mwe, exp_mbe, exp_maddr, exp_mwdata}) begin
                errors++;
                $display("FAIL rand_mbus[%0d]: got %b %b %h %h %h want %b %b %h %h %h", n,
                         m_en, m_we, m_be, m_addr, m_wdata, exp_men, exp_mwe, exp_mbe, exp_maddr, exp_mwdata);
            end
            checks++;
            if ({i_rvalid, i_rdata, d_rvalid, d_rdata} !== {exp_irv, exp_ird, exp_drv, exp_drd}) begin
                errors++;
                $display("FAIL rand_resp[%0d]: got i %b %h d %b %h want i %b %h d %b %h", n,
                         i_rvalid, i_rdata, d_rvalid, d_rdata, exp_irv, exp_ird, exp_drv, exp_drd);
            end
            advance();
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            logic [DW-1:0] v;
            v = $urandom;
            mem[a] = v;
            ref_mem[a] = v;
        end
        mem[12'h010] = 32'hDEAD_BEEF;
        ref_mem[12'h010] = 32'hDEAD_BEEF;
        test_reset();
        test_ifetch();
        test_write_merge();
        test_conflict();
        test_back_to_back();
        test_reset_inflight();
        test_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
